sync_source: RTL and testbench

SYNC_SOURCE -- requirements
Module: sync_source

---
 rtl/sync_source_pkg.sv | 27 ++
 rtl/sync_period_cnt.sv | 45 ++++
 rtl/sync_source.sv | 116 +++++++++++
 tb/tb_sync_source.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_source_pkg.sv
// Shared types and constants for the sync frame source.
// Covers the FSM state encoding, the frame timing constants and the period clamp.
package sync_source_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_WAIT
    } state_t;

    localparam int SYNC_W        = 32;
    localparam int PERIOD_W      = 16;
    localparam int STROBE_CYCLES = 2;
    localparam int HOLD_CYCLES   = 1;
    localparam int MIN_PERIOD    = 4;

    localparam int PHASE_W = 2;
    localparam logic [PHASE_W-1:0] STROBE_LAST = PHASE_W'(STROBE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'(HOLD_CYCLES - 1);

    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : p;
    endfunction

endpackage

// File: rtl/sync_period_cnt.sv
// Frame period counter: holds the clamped effective period, counts cycles since SETUP
// and raises a sticky error when a too-short period is sampled.
module sync_period_cnt
    import sync_source_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                sample,
    input  logic                restart,
    input  logic                advance,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                at_last,
    output logic                err_o
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] eff_period;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            eff_period <= PERIOD_W'(MIN_PERIOD);
            err_o      <= 1'b0;
        end else begin
            if (sample) begin
                eff_period <= clamp_period(period_i);
                if (period_i < PERIOD_W'(MIN_PERIOD)) begin
                    err_o <= 1'b1;
                end
            end
            // cnt equals the number of cycles elapsed since the SETUP cycle
            if (clear) begin
                cnt <= '0;
            end else if (restart) begin
                cnt <= PERIOD_W'(1);
            end else if (advance) begin
                cnt <= cnt + PERIOD_W'(1);
            end
        end
    end

    assign at_last = (cnt == eff_period - PERIOD_W'(1));

endmodule

// File: rtl/sync_source.sv
// Sync frame source: periodically presents a sequence word on sync_o framed by a
// two-cycle srdyo strobe with one hold cycle after the strobe falls.
module sync_source
    import sync_source_pkg::*;
(
    input  logic                Clk,
    input  logic                GlobalReset,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [SYNC_W-1:0]   seed_i,
    input  logic                load_i,
    output logic [SYNC_W-1:0]   sync_o,
    output logic                srdyo,
    output logic                busy_o,
    output logic                err_o
);

    state_t               state;
    logic [PHASE_W-1:0]   phase;
    logic [SYNC_W-1:0]    seq;
    logic                 at_last;
    logic                 hold_done;
    logic                 setup_entry;

    sync_period_cnt u_period (
        .clk      (Clk),
        .rst      (GlobalReset),
        .sample   (setup_entry),
        .restart  (state == S_SETUP),
        .advance  (state == S_STROBE || state == S_HOLD || state == S_WAIT),
        .clear    (state == S_IDLE),
        .period_i (period_i),
        .at_last  (at_last),
        .err_o    (err_o)
    );

    // SETUP entry is decided combinationally so the word, sequence and period
    // sample all update on the same edge that moves the FSM into SETUP.
    always_comb begin
        hold_done   = (state == S_HOLD) && (phase == HOLD_LAST);
        setup_entry = en && ((state == S_IDLE) ||
                             ((hold_done || state == S_WAIT) && at_last));
    end

    always_ff @(posedge Clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state  <= S_IDLE;
            phase  <= '0;
            seq    <= '0;
            sync_o <= '0;
            srdyo  <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            // load wins over the increment when both land on the SETUP edge
            if (load_i) begin
                seq <= setup_entry ? seed_i + SYNC_W'(1) : seed_i;
            end else if (setup_entry) begin
                seq <= seq + SYNC_W'(1);
            end
            if (setup_entry) begin
                sync_o <= load_i ? seed_i : seq;
            end

            case (state)
                S_IDLE: begin
                    if (setup_entry) begin
                        state  <= S_SETUP;
                        busy_o <= 1'b1;
                    end
                end
                S_SETUP: begin
                    state <= S_STROBE;
                    srdyo <= 1'b1;
                    phase <= '0;
                end
                S_STROBE: begin
                    if (phase == STROBE_LAST) begin
                        state <= S_HOLD;
                        srdyo <= 1'b0;
                        phase <= '0;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                S_HOLD: begin
                    if (hold_done) begin
                        if (!en) begin
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end else if (setup_entry) begin
                            state <= S_SETUP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!en) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else if (setup_entry) begin
                        state <= S_SETUP;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    srdyo  <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_source.sv
// Directed bench for sync_source: frame timing, period clamp, sequence load/wrap,
// enable drop and asynchronous reset behaviour.
module tb_sync_source;

    logic        Clk;
    logic        GlobalReset;
    logic        en;
    logic [15:0] period_i;
    logic [31:0] seed_i;
    logic        load_i;
    logic [31:0] sync_o;
    logic        srdyo;
    logic        busy_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sync_source dut (
        .Clk         (Clk),
        .GlobalReset (GlobalReset),
        .en          (en),
        .period_i    (period_i),
        .seed_i      (seed_i),
        .load_i      (load_i),
        .sync_o      (sync_o),
        .srdyo       (srdyo),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic wait_rise(input int limit, output bit ok);
        logic prev;
        prev = srdyo;
        ok   = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge Clk);
            if (srdyo && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = srdyo;
        end
    endtask

    task automatic apply_reset(input logic en_v, input logic [15:0] per);
        @(negedge Clk);
        GlobalReset = 1'b1;
        en          = 1'b0;
        load_i      = 1'b0;
        repeat (2) @(negedge Clk);
        en          = en_v;
        period_i    = per;
        GlobalReset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge Clk);
        checks++; if (sync_o !== 32'h0) begin failures++; $display("FAIL reset_sync got=%h exp=%h", sync_o, 32'h0); end
        checks++; if (srdyo !== 1'b0) begin failures++; $display("FAIL reset_srdyo got=%b exp=0", srdyo); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
    endtask

    task automatic test_period10;
        bit ok;
        int last;
        last = 0;
        apply_reset(1'b1, 16'd10);
        for (int f = 0; f < 3; f++) begin
            wait_rise(200, ok);
            checks++; if (!ok) begin failures++; $display("FAIL p10_timeout frame=%0d", f); end
            checks++; if (sync_o !== 32'(f)) begin failures++; $display("FAIL p10_sync got=%h exp=%h", sync_o, 32'(f)); end
            checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL p10_busy got=%b exp=1", busy_o); end
            if (f > 0) begin
                checks++; if (cyc - last !== 10) begin failures++; $display("FAIL p10_interval got=%0d exp=10", cyc - last); end
            end
            last = cyc;
            @(negedge Clk);
            checks++; if (srdyo !== 1'b1) begin failures++; $display("FAIL p10_strobe2 got=%b exp=1", srdyo); end
            @(negedge Clk);
            checks++; if (srdyo !== 1'b0) begin failures++; $display("FAIL p10_hold_srdyo got=%b exp=0", srdyo); end
            checks++; if (sync_o !== 32'(f)) begin failures++; $display("FAIL p10_hold_sync got=%h exp=%h", sync_o, 32'(f)); end
        end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL p10_err got=%b exp=0", err_o); end
    endtask

    task automatic test_min_period_err;
        bit ok;
        int last;
        last = 0;
        apply_reset(1'b1, 16'd2);
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL minp_err_pre got=%b exp=0", err_o); end
        for (int f = 0; f < 3; f++) begin
            wait_rise(200, ok);
            checks++; if (!ok) begin failures++; $display("FAIL minp_timeout frame=%0d", f); end
            checks++; if (sync_o !== 32'(f)) begin failures++; $display("FAIL minp_sync got=%h exp=%h", sync_o, 32'(f)); end
            checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL minp_err got=%b exp=1", err_o); end
            if (f > 0) begin
                checks++; if (cyc - last !== 4) begin failures++; $display("FAIL minp_interval got=%0d exp=4", cyc - last); end
            end
            last = cyc;
        end
        period_i = 16'd10;
        repeat (30) @(negedge Clk);
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL minp_err_sticky got=%b exp=1", err_o); end
    endtask

    task automatic test_wrap_load;
        bit ok;
        int last;
        logic [31:0] exp_v [3];
        exp_v[0] = 32'hFFFF_FFFE;
        exp_v[1] = 32'hFFFF_FFFF;
        exp_v[2] = 32'h0000_0000;
        apply_reset(1'b1, 16'd6);
        wait_rise(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_first_timeout"); end
        last = cyc;
        repeat (3) @(negedge Clk);
        load_i = 1'b1;
        seed_i = 32'hFFFF_FFFE;
        @(negedge Clk);
        load_i = 1'b0;
        checks++; if (sync_o !== 32'h0) begin failures++; $display("FAIL wrap_sync_after_load got=%h exp=%h", sync_o, 32'h0); end
        for (int f = 0; f < 3; f++) begin
            wait_rise(200, ok);
            checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout frame=%0d", f); end
            checks++; if (sync_o !== exp_v[f]) begin failures++; $display("FAIL wrap_sync got=%h exp=%h", sync_o, exp_v[f]); end
            checks++; if (cyc - last !== 6) begin failures++; $display("FAIL wrap_interval got=%0d exp=6", cyc - last); end
            last = cyc;
        end
    endtask

    task automatic test_load_at_setup;
        bit ok;
        int start;
        int last;
        apply_reset(1'b0, 16'd5);
        repeat (3) @(negedge Clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL lset_idle_busy got=%b exp=0", busy_o); end
        en     = 1'b1;
        load_i = 1'b1;
        seed_i = 32'h1234_5678;
        start  = cyc;
        @(negedge Clk);
        load_i = 1'b0;
        wait_rise(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lset_timeout"); end
        checks++; if (cyc - start !== 2) begin failures++; $display("FAIL lset_first_latency got=%0d exp=2", cyc - start); end
        checks++; if (sync_o !== 32'h1234_5678) begin failures++; $display("FAIL lset_sync0 got=%h exp=%h", sync_o, 32'h1234_5678); end
        last = cyc;
        wait_rise(200, ok);
        checks++; if (sync_o !== 32'h1234_5679) begin failures++; $display("FAIL lset_sync1 got=%h exp=%h", sync_o, 32'h1234_5679); end
        checks++; if (cyc - last !== 5) begin failures++; $display("FAIL lset_interval got=%0d exp=5", cyc - last); end
    endtask

    task automatic test_en_drop;
        bit ok;
        apply_reset(1'b1, 16'd8);
        wait_rise(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL endrop_timeout"); end
        en = 1'b0;
        @(negedge Clk);
        checks++; if (srdyo !== 1'b1) begin failures++; $display("FAIL endrop_strobe2 got=%b exp=1", srdyo); end
        @(negedge Clk);
        checks++; if (srdyo !== 1'b0) begin failures++; $display("FAIL endrop_hold_srdyo got=%b exp=0", srdyo); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL endrop_hold_busy got=%b exp=1", busy_o); end
        @(negedge Clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL endrop_idle_busy got=%b exp=0", busy_o); end
        repeat (12) @(negedge Clk);
        checks++; if (srdyo !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL endrop_stays_idle got=%b%b exp=00", srdyo, busy_o); end
    endtask

    task automatic test_reset_mid_strobe;
        bit ok;
        apply_reset(1'b1, 16'd7);
        wait_rise(200, ok);
        wait_rise(200, ok);
        checks++; if (!ok || sync_o !== 32'h1) begin failures++; $display("FAIL rstmid_pre got=%h exp=%h", sync_o, 32'h1); end
        #2 GlobalReset = 1'b1;
        #1;
        checks++; if (srdyo !== 1'b0) begin failures++; $display("FAIL rstmid_srdyo got=%b exp=0", srdyo); end
        checks++; if (sync_o !== 32'h0) begin failures++; $display("FAIL rstmid_sync got=%h exp=%h", sync_o, 32'h0); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
        @(negedge Clk);
        GlobalReset = 1'b0;
        wait_rise(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout"); end
        checks++; if (sync_o !== 32'h0) begin failures++; $display("FAIL rstmid_first_sync got=%h exp=%h", sync_o, 32'h0); end
    endtask

    initial begin
        GlobalReset = 1'b1;
        en          = 1'b1;
        period_i    = 16'd10;
        seed_i      = 32'hDEAD_BEEF;
        load_i      = 1'b0;
        test_reset();
        test_period10();
        test_min_period_err();
        test_wrap_load();
        test_load_at_setup();
        test_en_drop();
        test_reset_mid_strobe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
